rob_commit_ctrl: RTL and testbench
==================================

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 rdy  input  1  global enable; 0 freezes all state.
REQ-004 ID_alloc_valid  input  1  ID requests a reorder entry this cycle.
REQ-005 ID_reg_dest  input  5  destination register of allocating instruction; 0 = no register write.
REQ-006 ID_alloc_tag  output  4  tag for this cycle's allocation (combinational, = tail+1; tags 1..8, 0 = null).
REQ-007 ROB_full  output  1  combinational, 1 when count == 8.
REQ-008 CDB_valid  input  1  execution result broadcast.
REQ-009 CDB_tag  input  4  tag of result.
REQ-010 CDB_data  input  32  result value.
REQ-011 CDB_mispredict  input  1  result's instruction mispredicted.
REQ-012 CDB_target_pc  input  32  correct PC when CDB_mispredict = 1.
REQ-013 ROB_data_valid  output  1  registered regfile write pulse.
REQ-014 ROB_reg_dest  output  5  registered regfile write address.
REQ-015 ROB_tag  output  4  registered tag of committing entry.
REQ-016 ROB_data  output  32  registered regfile write data.
REQ-017 ROB_flush  output  1  registered one-cycle flush pulse.
REQ-018 ROB_flush_pc  output  32  registered redirect PC, meaningful when ROB_flush = 1.

Function
REQ-019 Storage SHALL be an 8-entry circular buffer; fields per entry: busy, ready, dest[4:0], data[31:0], mispredict, target_pc[31:0]; head/tail 3-bit wrapping modulo 8; count 4-bit (0..8).
REQ-020 FSM SHALL have states NORMAL and FLUSH; reset state NORMAL.
REQ-021 Allocation SHALL occur in NORMAL when rdy && ID_alloc_valid && !ROB_full: entry[tail] <- busy=1, ready=0, dest=ID_reg_dest, mispredict=0; tail++; count++.
REQ-022 Allocation requested while full or in FLUSH SHALL be ignored with no state change.
REQ-023 CDB write SHALL, in NORMAL when rdy && CDB_valid && CDB_tag != 0 and entry[CDB_tag-1].busy, set ready=1, data, mispredict, target_pc; CDB to a non-busy entry or tag 0 SHALL be ignored.
REQ-024 Commit SHALL retire at most one entry per cycle, in NORMAL when rdy and entry[head].busy && ready (as registered at cycle start): clear busy, head++, count--.
REQ-025 A CDB result for the head entry SHALL NOT commit in the same cycle; earliest commit is the following cycle.
REQ-026 On commit with dest != 0, next cycle ROB_data_valid=1, ROB_reg_dest=dest, ROB_tag=head+1, ROB_data=data; with dest == 0, ROB_data_valid=0.
REQ-027 Allocate and commit in the same cycle SHALL leave count unchanged; count 8 with simultaneous commit does not admit an allocation that cycle (ROB_full uses registered count).
REQ-028 On commit of an entry with mispredict=1, the register write of REQ-026 SHALL still occur, and next cycle ROB_flush=1, ROB_flush_pc=target_pc; all busy bits cleared, head=tail=0, count=0; FSM -> FLUSH.
REQ-029 FLUSH SHALL last exactly one cycle, ignoring allocation, CDB and commit, then return to NORMAL.
REQ-030 ROB_data_valid and ROB_flush SHALL be single-cycle pulses, deasserted in any cycle without a fresh commit, including rdy=0 cycles.
REQ-031 With rdy=0, buffer contents, pointers, count and FSM state SHALL hold.

Reset
REQ-032 rst=0 SHALL asynchronously clear all busy/ready bits, head, tail, count, FSM to NORMAL, and all registered outputs to 0, regardless of operation in progress.
REQ-033 After rst returns to 1, ID_alloc_tag=1, ROB_full=0 at the next cycle.

Verification
REQ-034 Alloc dest=5 (tag 1), CDB tag 1 data 0xDEADBEEF -> two cycles after CDB: ROB_data_valid=1, ROB_reg_dest=5, ROB_tag=1, ROB_data=0xDEADBEEF for one cycle.
REQ-035 Allocate 8 entries -> ROB_full=1, 9th alloc ignored; complete tag 1 -> commit, ROB_full=0; next alloc gets tag 1 (wrap).
REQ-036 Complete tags 2 then 1 -> commits in order tag 1 then tag 2 on consecutive cycles.
REQ-037 Three entries, tag 1 completes with mispredict, target 0x1000 -> ROB_flush=1, ROB_flush_pc=0x1000 for one cycle; count=0; alloc in FLUSH ignored; next alloc tag 1.
REQ-038 Assert rst=0 mid-clock with 4 entries pending -> outputs 0 immediately; after release, late CDB tag 2 produces no commit.

Source files
------------

// File: rtl/rob_commit_ctrl_if.sv
// Purpose: bundles the allocate, result-broadcast and commit buses of the reorder buffer.
// Latency: none; this is wiring only.
// Backpressure: ROB_full tells the allocating side to hold off; there is no other flow control.
// Ports: master = decode/execute/regfile side, slave = the reorder buffer itself.
interface rob_commit_ctrl_if;
   // allocation from decode
   logic        ID_alloc_valid;
   logic [4:0]  ID_reg_dest;
   logic [3:0]  ID_alloc_tag;
   logic        ROB_full;
   // result broadcast
   logic        CDB_valid;
   logic [3:0]  CDB_tag;
   logic [31:0] CDB_data;
   logic        CDB_mispredict;
   logic [31:0] CDB_target_pc;
   // commit / redirect
   logic        ROB_data_valid;
   logic [4:0]  ROB_reg_dest;
   logic [3:0]  ROB_tag;
   logic [31:0] ROB_data;
   logic        ROB_flush;
   logic [31:0] ROB_flush_pc;

   modport master (
      output ID_alloc_valid, ID_reg_dest,
      output CDB_valid, CDB_tag, CDB_data, CDB_mispredict, CDB_target_pc,
      input  ID_alloc_tag, ROB_full,
      input  ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data, ROB_flush, ROB_flush_pc
   );

   modport slave (
      input  ID_alloc_valid, ID_reg_dest,
      input  CDB_valid, CDB_tag, CDB_data, CDB_mispredict, CDB_target_pc,
      output ID_alloc_tag, ROB_full,
      output ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data, ROB_flush, ROB_flush_pc
   );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Purpose: 8-entry reorder buffer that retires results in order and flushes on a mispredicted commit.
// Latency: a result commits no earlier than the cycle after its broadcast; commit outputs are registered.
// Backpressure: ROB_full (count == 8) blocks allocation; rdy = 0 freezes everything.
// Ports: clk, rst (async active-low), rdy (global enable), bus (slave side of rob_commit_ctrl_if).
module rob_commit_ctrl (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   rob_commit_ctrl_if.slave bus
);

   typedef enum logic {NORMAL, FLUSH} state_t;

   state_t      state;
   logic [7:0]  busy;
   logic [7:0]  ready;
   logic [7:0]  mispredict;
   logic [4:0]  dest      [8];
   logic [31:0] data      [8];
   logic [31:0] target_pc [8];
   logic [2:0]  head;
   logic [2:0]  tail;
   logic [3:0]  count;

   logic        out_data_valid;
   logic [4:0]  out_reg_dest;
   logic [3:0]  out_tag;
   logic [31:0] out_data;
   logic        out_flush;
   logic [31:0] out_flush_pc;

   logic        full;
   logic        active;
   logic        cdb_in_range;
   logic [2:0]  cdb_idx;
   logic        do_alloc;
   logic        do_cdb;
   logic        do_commit;
   logic        commit_flush;

   // Tags are entry index + 1 so that tag 0 can mean "no producer".
   assign full         = (count == 4'd8);
   assign active       = rdy && (state == NORMAL);
   assign cdb_in_range = (bus.CDB_tag != 4'd0) && (bus.CDB_tag <= 4'd8);
   assign cdb_idx      = bus.CDB_tag[2:0] - 3'd1;

   assign do_alloc     = active && bus.ID_alloc_valid && !full;
   assign do_cdb       = active && bus.CDB_valid && cdb_in_range && busy[cdb_idx];
   // Uses the registered ready bit, so a broadcast to the head commits one cycle later.
   assign do_commit    = active && busy[head] && ready[head];
   assign commit_flush = do_commit && mispredict[head];

   assign bus.ID_alloc_tag   = {1'b0, tail} + 4'd1;
   assign bus.ROB_full       = full;
   assign bus.ROB_data_valid = out_data_valid;
   assign bus.ROB_reg_dest   = out_reg_dest;
   assign bus.ROB_tag        = out_tag;
   assign bus.ROB_data       = out_data;
   assign bus.ROB_flush      = out_flush;
   assign bus.ROB_flush_pc   = out_flush_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= NORMAL;
         busy           <= '0;
         ready          <= '0;
         mispredict     <= '0;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         out_data_valid <= 1'b0;
         out_reg_dest   <= '0;
         out_tag        <= '0;
         out_data       <= '0;
         out_flush      <= 1'b0;
         out_flush_pc   <= '0;
         for (int i = 0; i < 8; i++) begin
            dest[i]      <= '0;
            data[i]      <= '0;
            target_pc[i] <= '0;
         end
      end else begin
         // Pulses drop in every cycle that does not commit, stalled cycles included.
         out_data_valid <= 1'b0;
         out_flush      <= 1'b0;

         if (rdy) begin
            if (state == FLUSH) begin
               state <= NORMAL;
            end else begin
               if (do_alloc) begin
                  busy[tail]       <= 1'b1;
                  ready[tail]      <= 1'b0;
                  mispredict[tail] <= 1'b0;
                  dest[tail]       <= bus.ID_reg_dest;
               end

               if (do_cdb) begin
                  ready[cdb_idx]      <= 1'b1;
                  data[cdb_idx]       <= bus.CDB_data;
                  mispredict[cdb_idx] <= bus.CDB_mispredict;
                  target_pc[cdb_idx]  <= bus.CDB_target_pc;
               end

               // Commit writes come last so they win over a broadcast to the head entry.
               if (do_commit) begin
                  busy[head]     <= 1'b0;
                  ready[head]    <= 1'b0;
                  out_data_valid <= (dest[head] != 5'd0);
                  out_reg_dest   <= dest[head];
                  out_tag        <= {1'b0, head} + 4'd1;
                  out_data       <= data[head];
               end

               // A mispredicted commit still writes its register, then squashes everything younger.
               if (commit_flush) begin
                  busy         <= '0;
                  ready        <= '0;
                  head         <= '0;
                  tail         <= '0;
                  count        <= '0;
                  out_flush    <= 1'b1;
                  out_flush_pc <= target_pc[head];
                  state        <= FLUSH;
               end else begin
                  head  <= head + 3'(do_commit);
                  tail  <= tail + 3'(do_alloc);
                  count <= count + 4'(do_alloc) - 4'(do_commit);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Purpose: directed bench for rob_commit_ctrl with a commit scoreboard.
// Latency: inputs change 1ns after the rising edge; outputs are read 1-2ns after the edge.
// Backpressure: none modelled beyond the ROB_full and rdy cases exercised below.
module tb_rob_commit_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   rob_commit_ctrl_if bus ();

   rob_commit_ctrl dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] tag;
      logic [4:0] dest;
   } exp_wr_t;

   exp_wr_t     wq[$];            // expected register writes, in commit order
   logic [31:0] mdata [1:8];      // last result broadcast per tag
   logic [3:0]  exp_tag;          // tag the next accepted allocation should get
   int          vectors     = 0;
   int          miscompares = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ID_alloc_valid = 1'b0;
      bus.ID_reg_dest    = '0;
      bus.CDB_valid      = 1'b0;
      bus.CDB_tag        = '0;
      bus.CDB_data       = '0;
      bus.CDB_mispredict = 1'b0;
      bus.CDB_target_pc  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rdy = 1'b1;
      idle_inputs();
      cyc();
      wq.delete();
      chk("rst_data_valid", 32'(bus.ROB_data_valid), 32'd0);
      chk("rst_flush",      32'(bus.ROB_flush),      32'd0);
      chk("rst_reg_dest",   32'(bus.ROB_reg_dest),   32'd0);
      chk("rst_flush_pc",   bus.ROB_flush_pc,        32'd0);
      rst = 1'b1;
      cyc();
      chk("rst_alloc_tag", 32'(bus.ID_alloc_tag), 32'd1);
      chk("rst_full",      32'(bus.ROB_full),     32'd0);
      exp_tag = 4'd1;
   endtask

   task automatic alloc(input logic [4:0] d, input bit accept);
      chk("alloc_tag", 32'(bus.ID_alloc_tag), 32'(exp_tag));
      bus.ID_alloc_valid = 1'b1;
      bus.ID_reg_dest    = d;
      cyc();
      bus.ID_alloc_valid = 1'b0;
      bus.ID_reg_dest    = '0;
      if (accept) begin
         if (d != 5'd0) wq.push_back('{tag: exp_tag, dest: d});
         exp_tag = (exp_tag == 4'd8) ? 4'd1 : exp_tag + 4'd1;
      end
   endtask

   task automatic cdb(input logic [3:0] t, input logic [31:0] d, input bit mp, input logic [31:0] pc);
      bus.CDB_valid      = 1'b1;
      bus.CDB_tag        = t;
      bus.CDB_data       = d;
      bus.CDB_mispredict = mp;
      bus.CDB_target_pc  = pc;
      if (t >= 4'd1 && t <= 4'd8) mdata[t] = d;
      cyc();
      idle_inputs();
   endtask

   // Every register write the DUT emits must match the oldest outstanding expectation.
   always @(posedge clk) begin : monitor
      exp_wr_t e;
      #2;
      if (rst === 1'b1 && bus.ROB_data_valid === 1'b1) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", 32'(bus.ROB_data_valid), 32'd0);
         end else begin
            e = wq.pop_front();
            chk("wr_dest", 32'(bus.ROB_reg_dest), 32'(e.dest));
            chk("wr_tag",  32'(bus.ROB_tag),      32'(e.tag));
            chk("wr_data", bus.ROB_data,          mdata[e.tag]);
         end
      end
   end

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      exp_tag = 4'd1;
      idle_inputs();

      // Single allocate / complete / commit.
      do_reset();
      alloc(5'd5, 1'b1);
      cdb(4'd1, 32'hDEADBEEF, 1'b0, 32'd0);
      chk("s1_no_same_cycle_commit", 32'(bus.ROB_data_valid), 32'd0);
      cyc();
      chk("s1_wr_valid", 32'(bus.ROB_data_valid), 32'd1);
      chk("s1_wr_dest",  32'(bus.ROB_reg_dest),   32'd5);
      chk("s1_wr_tag",   32'(bus.ROB_tag),        32'd1);
      chk("s1_wr_data",  bus.ROB_data,            32'hDEADBEEF);
      cyc();
      chk("s1_pulse_end", 32'(bus.ROB_data_valid), 32'd0);

      // Fill, reject when full, commit with simultaneous alloc attempt, wrap.
      do_reset();
      for (int i = 1; i <= 8; i++) alloc(5'(i), 1'b1);
      chk("s2_full", 32'(bus.ROB_full), 32'd1);
      alloc(5'd9, 1'b0);
      chk("s2_full_after_9th", 32'(bus.ROB_full), 32'd1);
      cdb(4'd1, 32'h1111_0001, 1'b0, 32'd0);
      alloc(5'd21, 1'b0);
      chk("s2_commit_valid", 32'(bus.ROB_data_valid), 32'd1);
      chk("s2_not_full",     32'(bus.ROB_full),       32'd0);
      alloc(5'd20, 1'b1);
      chk("s2_full_again", 32'(bus.ROB_full), 32'd1);
      for (int t = 2; t <= 8; t++) cdb(4'(t), 32'h2222_0000 + 32'(t), 1'b0, 32'd0);
      cdb(4'd1, 32'h3333_0001, 1'b0, 32'd0);
      repeat (3) cyc();
      chk("s2_drained",   32'(wq.size()),         32'd0);
      chk("s2_empty",     32'(bus.ROB_full),      32'd0);
      chk("s2_next_tag",  32'(bus.ID_alloc_tag),  32'd2);

      // Out-of-order completion, in-order commit.
      do_reset();
      alloc(5'd3, 1'b1);
      alloc(5'd4, 1'b1);
      cdb(4'd2, 32'hAAAA_0002, 1'b0, 32'd0);
      cdb(4'd1, 32'hBBBB_0001, 1'b0, 32'd0);
      chk("s3_wait", 32'(bus.ROB_data_valid), 32'd0);
      cyc();
      chk("s3_first_valid", 32'(bus.ROB_data_valid), 32'd1);
      chk("s3_first_tag",   32'(bus.ROB_tag),        32'd1);
      cyc();
      chk("s3_second_valid", 32'(bus.ROB_data_valid), 32'd1);
      chk("s3_second_tag",   32'(bus.ROB_tag),        32'd2);
      cyc();
      chk("s3_idle", 32'(bus.ROB_data_valid), 32'd0);

      // Global stall.
      do_reset();
      alloc(5'd7, 1'b1);
      rdy = 1'b0;
      cdb(4'd1, 32'h5555_0001, 1'b0, 32'd0);
      alloc(5'd8, 1'b0);
      rdy = 1'b1;
      repeat (2) begin
         cyc();
         chk("s4_cdb_ignored", 32'(bus.ROB_data_valid), 32'd0);
      end
      cdb(4'd1, 32'h6666_0001, 1'b0, 32'd0);
      rdy = 1'b0;
      cyc();
      chk("s4_commit_frozen", 32'(bus.ROB_data_valid), 32'd0);
      chk("s4_tag_held",      32'(bus.ID_alloc_tag),   32'd2);
      rdy = 1'b1;
      cyc();
      chk("s4_commit_valid", 32'(bus.ROB_data_valid), 32'd1);
      chk("s4_commit_data",  bus.ROB_data,            32'h6666_0001);
      rdy = 1'b0;
      cyc();
      chk("s4_pulse_drops_stalled", 32'(bus.ROB_data_valid), 32'd0);
      rdy = 1'b1;

      // Mispredicted commit flushes the buffer.
      do_reset();
      alloc(5'd1, 1'b1);
      alloc(5'd2, 1'b1);
      alloc(5'd3, 1'b1);
      cdb(4'd1, 32'h7777_0001, 1'b1, 32'h0000_1000);
      chk("s5_no_early_flush", 32'(bus.ROB_flush), 32'd0);
      cyc();
      chk("s5_flush",       32'(bus.ROB_flush),      32'd1);
      chk("s5_flush_pc",    bus.ROB_flush_pc,        32'h0000_1000);
      chk("s5_flush_write", 32'(bus.ROB_data_valid), 32'd1);
      chk("s5_tag_reset",   32'(bus.ID_alloc_tag),   32'd1);
      exp_tag = 4'd1;
      alloc(5'd9, 1'b0);
      chk("s5_flush_pulse_end",   32'(bus.ROB_flush),    32'd0);
      chk("s5_alloc_in_flush_ign", 32'(bus.ID_alloc_tag), 32'd1);
      wq.delete();
      cdb(4'd2, 32'h8888_0002, 1'b0, 32'd0);
      alloc(5'd6, 1'b1);
      cdb(4'd1, 32'h9999_0001, 1'b0, 32'd0);
      cyc();
      chk("s5_post_flush_valid", 32'(bus.ROB_data_valid), 32'd1);
      chk("s5_post_flush_dest",  32'(bus.ROB_reg_dest),   32'd6);
      cyc();
      chk("s5_squashed_no_write", 32'(bus.ROB_data_valid), 32'd0);

      // Asynchronous reset in the middle of a cycle.
      do_reset();
      for (int i = 0; i < 4; i++) alloc(5'd10 + 5'(i), 1'b1);
      cdb(4'd1, 32'hCAFE_0001, 1'b0, 32'd0);
      cyc();
      chk("s6_pre_reset_valid", 32'(bus.ROB_data_valid), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("s6_async_valid",     32'(bus.ROB_data_valid), 32'd0);
      chk("s6_async_dest",      32'(bus.ROB_reg_dest),   32'd0);
      chk("s6_async_tag",       32'(bus.ROB_tag),        32'd0);
      chk("s6_async_data",      bus.ROB_data,            32'd0);
      chk("s6_async_alloc_tag", 32'(bus.ID_alloc_tag),   32'd1);
      wq.delete();
      cyc();
      rst = 1'b1;
      cdb(4'd2, 32'hDEAD_0002, 1'b0, 32'd0);
      repeat (3) begin
         cyc();
         chk("s6_late_cdb_no_commit", 32'(bus.ROB_data_valid), 32'd0);
      end
      chk("s6_alloc_tag_after", 32'(bus.ID_alloc_tag), 32'd1);
      chk("s6_full_after",      32'(bus.ROB_full),     32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
